// File: rtl/lvl_debounce_pkg.sv
// Shared definitions for the level debouncer.
//   state_t          : qualification FSM states
//   DEF_SYNC_STAGES  : default synchroniser depth
//   DEF_DEB_CYCLES   : default number of stable samples to accept a change
package lvl_debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_QUAL_LO = 2'd3
  } state_t;

  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam int unsigned DEF_DEB_CYCLES  = 8;

endpackage

// File: rtl/lvl_debounce_bit_sync.sv
// Multi-flop synchroniser for a single asynchronous bit.
//   clk     : sampling clock
//   reset_n : synchronous active-low reset, clears every stage
//   d       : asynchronous input
//   q       : synchronised output (last stage)
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/lvl_debounce.sv
// Level debouncer: synchronises async_in and only changes lvl_out after
// DEB_CYCLES consecutive stable samples at the new level.
//   clk        : single clock, rising edge
//   reset_n    : synchronous active-low reset
//   async_in   : raw asynchronous level
//   enable     : 0 aborts any qualification and freezes lvl_out
//   lvl_out    : registered debounced level
//   busy       : registered, high while a transition is being qualified
//   glitch_cnt : saturating count of rejected transitions
module lvl_debounce
  import lvl_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       async_in,
  input  logic       enable,
  output logic       lvl_out,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  localparam logic [7:0] CNT_LAST = 8'(DEB_CYCLES - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       glitch_inc;
  logic       s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (async_in),
    .q       (s)
  );

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    glitch_inc = 1'b0;
    unique case (state)
      ST_LOW: begin
        if (enable && s) begin
          if (DEB_CYCLES == 1) begin
            state_nxt = ST_HIGH;
          end else begin
            state_nxt = ST_QUAL_HI;
            cnt_nxt   = 8'd1;
          end
        end
      end
      ST_QUAL_HI: begin
        // Disable aborts silently; a sample back at the old level is a glitch.
        if (!enable) begin
          state_nxt = ST_LOW;
        end else if (!s) begin
          state_nxt  = ST_LOW;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_HIGH: begin
        if (enable && !s) begin
          if (DEB_CYCLES == 1) begin
            state_nxt = ST_LOW;
          end else begin
            state_nxt = ST_QUAL_LO;
            cnt_nxt   = 8'd1;
          end
        end
      end
      ST_QUAL_LO: begin
        if (!enable) begin
          state_nxt = ST_HIGH;
        end else if (s) begin
          state_nxt  = ST_HIGH;
          glitch_inc = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = ST_LOW;
    endcase
  end

  // Outputs are decoded from the next state so they register on the same
  // edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_LOW;
      cnt        <= '0;
      lvl_out    <= 1'b0;
      busy       <= 1'b0;
      glitch_cnt <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      lvl_out <= (state_nxt == ST_HIGH) || (state_nxt == ST_QUAL_LO);
      busy    <= (state_nxt == ST_QUAL_HI) || (state_nxt == ST_QUAL_LO);
      if (glitch_inc && (glitch_cnt != 8'hFF)) begin
        glitch_cnt <= glitch_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lvl_debounce.sv
module tb_lvl_debounce;

  logic       clk = 1'b0;
  logic       reset_n, async_in, enable;
  logic       lvl_out, busy, lvl_out1, busy1;
  logic [7:0] glitch_cnt, glitch_cnt1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lvl_debounce #(.SYNC_STAGES(2), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (async_in),
    .enable     (enable),
    .lvl_out    (lvl_out),
    .busy       (busy),
    .glitch_cnt (glitch_cnt)
  );

  lvl_debounce #(.SYNC_STAGES(2), .DEB_CYCLES(1)) dut1 (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_in   (async_in),
    .enable     (enable),
    .lvl_out    (lvl_out1),
    .busy       (busy1),
    .glitch_cnt (glitch_cnt1)
  );

  // Behavioural reference: a 2-deep delay line, then a run-length counter of
  // samples that disagree with the accepted level. The level flips once the
  // run reaches DEB; a run broken by an agreeing sample is a glitch; enable=0
  // discards the run.
  bit m_sync [2][2];
  bit m_lvl  [2];
  int m_run  [2];
  int m_gl   [2];
  int m_deb  [2] = '{4, 1};

  task automatic model_step(input int k);
    bit s;
    if (!reset_n) begin
      m_sync[k][0] = 0; m_sync[k][1] = 0;
      m_lvl[k] = 0; m_run[k] = 0; m_gl[k] = 0;
    end else begin
      s = m_sync[k][1];
      m_sync[k][1] = m_sync[k][0];
      m_sync[k][0] = async_in;
      if (!enable) begin
        m_run[k] = 0;
      end else if (s != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == m_deb[k]) begin
          m_lvl[k] = s;
          m_run[k] = 0;
        end
      end else begin
        if (m_run[k] > 0 && m_gl[k] < 255) m_gl[k]++;
        m_run[k] = 0;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input bit exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs seen by this edge, then
  // compare both DUTs just after the edge.
  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_bit("model_lvl4", lvl_out, m_lvl[0]);
    check_bit("model_busy4", busy, m_run[0] > 0);
    check("model_glitch4", int'(glitch_cnt), m_gl[0]);
    check_bit("model_lvl1", lvl_out1, m_lvl[1]);
    check_bit("model_busy1", busy1, m_run[1] > 0);
    check("model_glitch1", int'(glitch_cnt1), m_gl[1]);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {
    bit       a;
    bit       en;
    bit       rn;
    bit       e_lvl;
    bit       e_busy;
    bit [7:0] e_gl;
    bit       e_lvl1;
  } vec_t;

  vec_t vt[9];

  initial begin
    int hold;
    // Reset edge, then a clean rise held from before edge 1.
    vt[0] = '{0, 1, 0, 0, 0, 8'd0, 0};
    vt[1] = '{1, 1, 1, 0, 0, 8'd0, 0};
    vt[2] = '{1, 1, 1, 0, 0, 8'd0, 0};
    vt[3] = '{1, 1, 1, 0, 1, 8'd0, 1};
    vt[4] = '{1, 1, 1, 0, 1, 8'd0, 1};
    vt[5] = '{1, 1, 1, 0, 1, 8'd0, 1};
    vt[6] = '{1, 1, 1, 1, 0, 8'd0, 1};
    vt[7] = '{1, 1, 1, 1, 0, 8'd0, 1};
    vt[8] = '{1, 1, 1, 1, 0, 8'd0, 1};

    reset_n = 0; async_in = 0; enable = 1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      async_in = vt[i].a; enable = vt[i].en; reset_n = vt[i].rn;
      tick();
      check_bit($sformatf("vec%0d_lvl", i), lvl_out, vt[i].e_lvl);
      check_bit($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
      check($sformatf("vec%0d_glitch", i), int'(glitch_cnt), int'(vt[i].e_gl));
      check_bit($sformatf("vec%0d_lvl_deb1", i), lvl_out1, vt[i].e_lvl1);
      check_bit($sformatf("vec%0d_busy_deb1", i), busy1, 1'b0);
    end

    // Short high pulse from LOW is rejected.
    reset_n = 0; async_in = 0; tick(); reset_n = 1;
    async_in = 1; ticks(2);
    async_in = 0; ticks(8);
    check_bit("rise_glitch_lvl", lvl_out, 1'b0);
    check_bit("rise_glitch_busy", busy, 1'b0);
    check("rise_glitch_cnt", int'(glitch_cnt), 1);
    // Short low pulse from HIGH is rejected.
    async_in = 1; ticks(10);
    check_bit("to_high_lvl", lvl_out, 1'b1);
    async_in = 0; ticks(2);
    async_in = 1; ticks(8);
    check_bit("fall_glitch_lvl", lvl_out, 1'b1);
    check("fall_glitch_cnt", int'(glitch_cnt), 2);

    // 300 isolated single-cycle low glitches saturate the counter.
    for (int i = 0; i < 300; i++) begin
      async_in = 0; tick();
      async_in = 1; tick();
    end
    ticks(4);
    check("glitch_sat", int'(glitch_cnt), 255);
    check_bit("glitch_sat_lvl", lvl_out, 1'b1);

    // One-cycle reset while high clears everything on that edge.
    reset_n = 0; tick();
    check_bit("rst_lvl", lvl_out, 1'b0);
    check("rst_glitch", int'(glitch_cnt), 0);
    reset_n = 1; ticks(5);
    check_bit("rst_rise_e5", lvl_out, 1'b0);
    tick();
    check_bit("rst_rise_e6", lvl_out, 1'b1);

    // Enable dropped during qualification aborts without counting a glitch.
    reset_n = 0; async_in = 0; tick(); reset_n = 1;
    async_in = 1; ticks(3);
    check_bit("qual_busy", busy, 1'b1);
    enable = 0; tick();
    check_bit("dis_busy", busy, 1'b0);
    check_bit("dis_lvl", lvl_out, 1'b0);
    check("dis_glitch", int'(glitch_cnt), 0);
    enable = 1; ticks(3);
    check_bit("reen_3", lvl_out, 1'b0);
    tick();
    check_bit("reen_4", lvl_out, 1'b1);

    // Randomised soak against the model.
    hold = 0;
    for (int i = 0; i < 2500; i++) begin
      if (hold == 0) begin
        async_in = $urandom_range(0, 1);
        hold = $urandom_range(1, 7);
      end
      hold--;
      enable  = ($urandom_range(0, 15) != 0);
      reset_n = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
